// File: rtl/branch_ctrl_pkg.sv
// Shared branch-unit defines: func3 encodings, link register index and group decode.
package branch_ctrl_pkg;

    // Unconditional group
    localparam logic [2:0] FUNC_B    = 3'd0;
    localparam logic [2:0] FUNC_BL   = 3'd1;
    localparam logic [2:0] FUNC_BLR  = 3'd2;
    localparam logic [2:0] FUNC_RET  = 3'd3;
    localparam logic [2:0] FUNC_ERET = 3'd4;

    // Conditional group
    localparam logic [2:0] FUNC_CBZ  = 3'd0;
    localparam logic [2:0] FUNC_CBNZ = 3'd1;
    localparam logic [2:0] FUNC_CBGE = 3'd2;
    localparam logic [2:0] FUNC_CBLT = 3'd3;
    localparam logic [2:0] FUNC_CBGT = 3'd4;
    localparam logic [2:0] FUNC_CBLE = 3'd5;

    localparam logic [4:0] LINK_REG = 5'd2;

    typedef enum logic [3:0] {
        OP_NONE,
        OP_B,
        OP_BL,
        OP_BLR,
        OP_RET,
        OP_ERET,
        OP_CBZ,
        OP_CBNZ,
        OP_CBGE,
        OP_CBLT,
        OP_CBGT,
        OP_CBLE,
        OP_ILLEGAL
    } br_op_e;

    function automatic br_op_e decode_op(input logic en, input logic uncon, input logic [2:0] func3);
        br_op_e op;
        op = OP_NONE;
        if (en) begin
            if (uncon) begin
                case (func3)
                    FUNC_B:    op = OP_B;
                    FUNC_BL:   op = OP_BL;
                    FUNC_BLR:  op = OP_BLR;
                    FUNC_RET:  op = OP_RET;
                    FUNC_ERET: op = OP_ERET;
                    default:   op = OP_ILLEGAL;
                endcase
            end else begin
                case (func3)
                    FUNC_CBZ:  op = OP_CBZ;
                    FUNC_CBNZ: op = OP_CBNZ;
                    FUNC_CBGE: op = OP_CBGE;
                    FUNC_CBLT: op = OP_CBLT;
                    FUNC_CBGT: op = OP_CBGT;
                    FUNC_CBLE: op = OP_CBLE;
                    default:   op = OP_ILLEGAL;
                endcase
            end
        end
        return op;
    endfunction

endpackage

// File: rtl/branch_ras.sv
// Circular return-address stack; only built when NAH_BRANCH_RAS_EN is defined.
// A push when full overwrites the oldest entry; the count saturates at DEPTH.
module branch_ras #(
    parameter int XLEN  = 16,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            valid
);

    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   ptr_reg;
    logic [PW:0]     count_reg;
    logic [PW-1:0]   top_idx;

    // ptr_reg is the next free slot, so the newest entry sits just below it
    assign top_idx = ptr_reg - PW'(1);
    assign top     = mem[top_idx];
    assign valid   = (count_reg != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg   <= '0;
            count_reg <= '0;
        end else if (push) begin
            ptr_reg <= ptr_reg + PW'(1);
            if (count_reg != (PW+1)'(DEPTH))
                count_reg <= count_reg + (PW+1)'(1);
        end else if (pop && valid) begin
            ptr_reg   <= top_idx;
            count_reg <= count_reg - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[ptr_reg] <= push_data;
    end

endmodule

// File: rtl/branch_ctrl.sv
// Registered branch-resolution unit with latched interrupt, EPC and ERET.
// Optional return-address stack enabled by defining NAH_BRANCH_RAS_EN.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int XLEN      = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            en,
    input  logic            uncon,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      rs1,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            int_req,
    input  logic [XLEN-1:0] mvec,
    input  logic            mask,
    output logic            redirect,
    output logic [XLEN-1:0] target,
    output logic            link,
    output logic [4:0]      link_rd,
    output logic [XLEN-1:0] link_data,
    output logic            clear,
    output logic            int_ack,
    output logic            illegal,
    output logic [XLEN-1:0] epc
);

    br_op_e          op;
    logic [XLEN-1:0] seq_pc, br_pc, reg_pc, ras_top, res_target;
    logic            ras_valid, zero, sign;
    logic            taken, lnk, clr, ill, push, pop;
    logic [4:0]      lrd;
    logic            pend_eff, take;

    logic            redirect_reg, link_reg, clear_reg, int_ack_reg, illegal_reg, pending_reg;
    logic [XLEN-1:0] target_reg, link_data_reg, epc_reg;
    logic [4:0]      link_rd_reg;

    logic            unused_bits;
    assign unused_bits = ^{imm[0], rs2_data[0]};

    assign op     = decode_op(en, uncon, func3);
    assign seq_pc = pc + XLEN'(4);
    assign br_pc  = pc + {imm[XLEN-1:1], 1'b0};
    assign reg_pc = {rs2_data[XLEN-1:1], 1'b0};
    assign zero   = (rs2_data == '0);
    assign sign   = rs2_data[XLEN-1];

    always_comb begin
        taken      = 1'b0;
        res_target = seq_pc;
        lnk        = 1'b0;
        lrd        = rs1;
        clr        = 1'b0;
        ill        = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        case (op)
            OP_B:    begin taken = 1'b1; res_target = br_pc; end
            OP_BL:   begin taken = 1'b1; res_target = br_pc; lnk = 1'b1; lrd = LINK_REG; push = 1'b1; end
            OP_BLR:  begin taken = 1'b1; res_target = reg_pc; lnk = 1'b1; push = 1'b1; end
            OP_RET:  begin taken = 1'b1; pop = 1'b1; res_target = ras_valid ? ras_top : reg_pc; end
            OP_ERET: begin taken = 1'b1; res_target = epc_reg; clr = 1'b1; end
            OP_CBZ:  taken = zero;
            OP_CBNZ: taken = !zero;
            OP_CBGE: taken = !sign;
            OP_CBLT: taken = sign;
            OP_CBGT: taken = !sign && !zero;
            OP_CBLE: taken = sign || zero;
            OP_ILLEGAL: ill = 1'b1;
            default: ;
        endcase
        if ((op >= OP_CBZ) && (op <= OP_CBLE) && taken)
            res_target = br_pc;
    end

    // ERET's clear is not yet visible to the mask source, so a take waits one cycle
    assign pend_eff = pending_reg || int_req;
    assign take     = pend_eff && !mask && (op != OP_ERET);

`ifdef NAH_BRANCH_RAS_EN
    branch_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push && !stall),
        .pop       (pop && !stall),
        .push_data (seq_pc),
        .top       (ras_top),
        .valid     (ras_valid)
    );
`else
    logic unused_ras;
    assign unused_ras = ^{push, pop, (RAS_DEPTH > 1)};
    assign ras_top    = '0;
    assign ras_valid  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_reg  <= 1'b0;
            target_reg    <= '0;
            link_reg      <= 1'b0;
            link_rd_reg   <= '0;
            link_data_reg <= '0;
            clear_reg     <= 1'b0;
            int_ack_reg   <= 1'b0;
            illegal_reg   <= 1'b0;
            epc_reg       <= '0;
            pending_reg   <= 1'b0;
        end else if (stall) begin
            redirect_reg <= 1'b0;
            link_reg     <= 1'b0;
            clear_reg    <= 1'b0;
            int_ack_reg  <= 1'b0;
            illegal_reg  <= 1'b0;
        end else begin
            redirect_reg <= taken || take;
            target_reg   <= take ? mvec : res_target;
            link_reg     <= lnk;
            if (lnk) begin
                link_rd_reg   <= lrd;
                link_data_reg <= seq_pc;
            end
            clear_reg   <= clr;
            int_ack_reg <= take;
            illegal_reg <= ill;
            if (take)
                epc_reg <= res_target;
            pending_reg <= pend_eff && !take;
        end
    end

    assign redirect  = redirect_reg;
    assign target    = target_reg;
    assign link      = link_reg;
    assign link_rd   = link_rd_reg;
    assign link_data = link_data_reg;
    assign clear     = clear_reg;
    assign int_ack   = int_ack_reg;
    assign illegal   = illegal_reg;
    assign epc       = epc_reg;

endmodule
